bram_tdp_be_clr: RTL and testbench

BRAM_TDP_BE_CLR -- requirements
Module: bram_tdp_be_clr

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_rd_pipe.sv | 51 +++++
 rtl/bram_tdp_be_clr.sv | 182 ++++++++++++++++++
 tb/tb_bram_tdp_be_clr.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and constants for the byte-enable true-dual-port RAM with
// built-in array clear.
package bram_pkg;

    // Clear sequencer states: IDLE serves normal traffic, CLEAR owns port A
    // and sweeps the whole array.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Same-port read-during-write selection for the RDW_MODE parameter.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data pipeline: STAGES registers of data plus valid. A data register
// only loads when its incoming valid is set, so the output word holds its
// last value between strobes. Stage 0 doubles as the array output register.
module bram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];

    // Shift valid every cycle; advance data only alongside a valid.
    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = in_vld;
        data_d[0] = in_vld ? in_data : data_q[0];
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s]  = vld_q[s-1];
            data_d[s] = vld_q[s-1] ? data_q[s-1] : data_q[s];
        end
    end

    // Pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    assign out_vld  = vld_q[STAGES-1];
    assign out_data = data_q[STAGES-1];

endmodule

// File: rtl/bram_tdp_be_clr.sv
// True-dual-port block RAM with per-byte write enables, configurable read
// latency and read-during-write mode, and a sequencer that fills the whole
// array with CLR_VAL (after reset and on request). While clearing, the
// sequencer borrows port A's write path and both user ports are ignored.
module bram_tdp_be_clr
    import bram_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter int                RD_LAT     = 1,
    parameter int                RDW_MODE   = 0,
    parameter int                CLR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                vlda,
    input  logic                enb,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   doutb,
    output logic                vldb,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done,
    output logic                coll
);

    localparam int              NB        = DATA_W / 8;
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // Storage; deliberately never reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_done_q, clr_done_d;
    logic              coll_q, coll_d;

    logic              acc_a, acc_b;
    logic [NB-1:0]     wr_be_a, wr_be_b;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [DATA_W-1:0] wr_data_a;
    logic [DATA_W-1:0] rd_word_a, rd_word_b;

    // Overlay the bytes of new_w selected by be onto old_w.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign busy = (state_q == CLEAR);

    // Clear sequencer: sweep every address once, then pulse clr_done.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port arbitration: the clear takes over port A; on a same-address double
    // write, B's bytes are suppressed wherever A also writes so A wins.
    always_comb begin
        acc_a     = ena & ~busy;
        acc_b     = enb & ~busy;
        wr_addr_a = addra;
        wr_data_a = dina;
        wr_be_a   = acc_a ? wea : '0;
        if (busy) begin
            wr_addr_a = clr_addr_q;
            wr_data_a = CLR_VAL;
            wr_be_a   = '1;
        end
        wr_be_b = acc_b ? web : '0;
        if (acc_a && (addra == addrb)) begin
            wr_be_b = wr_be_b & ~wea;
        end
        coll_d = acc_a & acc_b & (|wea) & (|web) & (addra == addrb);
    end

    // Read words: the stored (pre-write) word, or in write-first mode the
    // word merged with this port's own write. The other port's write in the
    // same cycle is never visible.
    always_comb begin
        rd_word_a = mem[addra];
        rd_word_b = mem[addrb];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            rd_word_a = byte_merge(mem[addra], dina, acc_a ? wea : '0);
            rd_word_b = byte_merge(mem[addrb], dinb, acc_b ? web : '0);
        end
    end

    // Byte-lane writes for both ports.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be_a[i]) begin
                mem[wr_addr_a][8*i +: 8] <= wr_data_a[8*i +: 8];
            end
            if (wr_be_b[i]) begin
                mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
            end
        end
    end

    // Control registers; reset (re)starts a clear when CLR_ON_RST is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
            coll_q     <= coll_d;
        end
    end

    assign clr_done = clr_done_q;
    assign coll     = coll_q;

    bram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (acc_a),
        .in_data  (rd_word_a),
        .out_vld  (vlda),
        .out_data (douta)
    );

    bram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (acc_b),
        .in_data  (rd_word_b),
        .out_vld  (vldb),
        .out_data (doutb)
    );

endmodule

// File: tb/tb_bram_tdp_be_clr.sv
// Bench for bram_tdp_be_clr. Two instances share one stimulus stream:
// dut0 = RD_LAT 1, read-first, clear value 0; dut1 = RD_LAT 2, write-first,
// clear value 0xDEADBEEF. Expected read words are queued when an access is
// driven and popped when the matching vld strobe appears.
module tb_bram_tdp_be_clr;

    localparam logic [31:0] CV0 = 32'h0000_0000;
    localparam logic [31:0] CV1 = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n, ena, enb, clr_req;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] douta [2];
    logic [31:0] doutb [2];
    logic        vlda [2];
    logic        vldb [2];
    logic        busy [2];
    logic        clr_done [2];
    logic        coll [2];

    always #5 clk = ~clk;

    bram_tdp_be_clr #(.ADDR_W(4), .DATA_W(32), .RD_LAT(1), .RDW_MODE(0),
                      .CLR_ON_RST(1), .CLR_VAL(CV0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .vlda(vlda[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .vldb(vldb[0]),
        .clr_req(clr_req), .busy(busy[0]), .clr_done(clr_done[0]), .coll(coll[0]));

    bram_tdp_be_clr #(.ADDR_W(4), .DATA_W(32), .RD_LAT(2), .RDW_MODE(1),
                      .CLR_ON_RST(1), .CLR_VAL(CV1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .vlda(vlda[1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .vldb(vldb[1]),
        .clr_req(clr_req), .busy(busy[1]), .clr_done(clr_done[1]), .coll(coll[1]));

    typedef struct {
        logic        ena;  logic [3:0] wea; logic [3:0] addra; logic [31:0] dina;
        logic        enb;  logic [3:0] web; logic [3:0] addrb; logic [31:0] dinb;
        logic [31:0] xa0;  logic [31:0] xa1; logic [31:0] xb0;  logic [31:0] xb1;
        logic        cmpa; logic cmpb;      logic xcoll;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        cmp;
        int          due;
    } sb_t;

    // Queue index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    sb_t q0[$];
    sb_t q1[$];
    sb_t q2[$];
    sb_t q3[$];

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          coll_due = -1;
    logic        mon_en   = 1'b0;
    logic [31:0] last_dout [4];
    vec_t        tbl [11];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int qdue(input int k);
        case (k)
            0:       return q0[0].due;
            1:       return q1[0].due;
            2:       return q2[0].due;
            default: return q3[0].due;
        endcase
    endfunction

    function automatic sb_t qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic qpush(input int k, input sb_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic expv(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_port(input int k, input string nm, input logic vld, input logic [31:0] dout);
        sb_t e;
        if (qsize(k) > 0 && qdue(k) < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s vld missing: due cycle %0d, now cycle %0d", nm, qdue(k), cyc);
            e = qpop(k);
        end
        checks++;
        if (vld) begin
            if (qsize(k) == 0) begin
                errors++;
                $display("FAIL %s unexpected vld: got 1 want 0 (dout %h) cycle %0d", nm, dout, cyc);
            end else begin
                e = qpop(k);
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL %s vld latency: got cycle %0d want cycle %0d", nm, cyc, e.due);
                end
                if (e.cmp) begin
                    checks++;
                    if (dout !== e.data) begin
                        errors++;
                        $display("FAIL %s dout: got %h want %h", nm, dout, e.data);
                    end
                end
            end
            last_dout[k] = dout;
        end else if (dout !== last_dout[k]) begin
            errors++;
            $display("FAIL %s dout hold: got %h want %h", nm, dout, last_dout[k]);
        end
    endtask

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) last_dout[k] = '0;
        end else if (mon_en) begin
            chk_port(0, "A0", vlda[0], douta[0]);
            chk_port(1, "B0", vldb[0], doutb[0]);
            chk_port(2, "A1", vlda[1], douta[1]);
            chk_port(3, "B1", vldb[1], doutb[1]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (coll[d] !== (cyc == coll_due)) begin
                    errors++;
                    $display("FAIL coll%0d cycle %0d: got %b want %b", d, cyc, coll[d], (cyc == coll_due));
                end
            end
        end
    end

    // Apply one vector for a cycle; queue expectations if the access is accepted.
    task automatic drive(input vec_t v, input bit acc);
        sb_t e;
        ena = v.ena; wea = v.wea; addra = v.addra; dina = v.dina;
        enb = v.enb; web = v.web; addrb = v.addrb; dinb = v.dinb;
        if (acc) begin
            if (v.ena) begin
                e.cmp = v.cmpa;
                e.data = v.xa0; e.due = cyc + 1; qpush(0, e);
                e.data = v.xa1; e.due = cyc + 2; qpush(2, e);
            end
            if (v.enb) begin
                e.cmp = v.cmpb;
                e.data = v.xb0; e.due = cyc + 1; qpush(1, e);
                e.data = v.xb1; e.due = cyc + 2; qpush(3, e);
            end
            if (v.xcoll) coll_due = cyc + 1;
        end
        @(posedge clk); #1;
    endtask

    function automatic vec_t mkvec(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                                   input logic [31:0] da, input logic eb, input logic [3:0] wb,
                                   input logic [3:0] ab, input logic [31:0] db,
                                   input logic [31:0] xa0, input logic [31:0] xa1,
                                   input logic [31:0] xb0, input logic [31:0] xb1,
                                   input logic ca, input logic cb, input logic xc);
        vec_t v;
        v.ena = ea; v.wea = wa; v.addra = aa; v.dina = da;
        v.enb = eb; v.web = wb; v.addrb = ab; v.dinb = db;
        v.xa0 = xa0; v.xa1 = xa1; v.xb0 = xb0; v.xb1 = xb1;
        v.cmpa = ca; v.cmpb = cb; v.xcoll = xc;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    endtask

    // Count busy cycles until clr_done; optionally poke clr_req/ena/enb mid-clear.
    task automatic wait_clear(input bit poke);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            if (clr_done[0] === 1'b1) begin
                done = 1;
                break;
            end
            if (busy[0] === 1'b1) n++;
            if (poke) begin
                clr_req = (i >= 3 && i < 6);
                ena = clr_req; enb = clr_req; wea = 4'hF; web = 4'hF;
                addra = 4'd4; addrb = 4'd6; dina = 32'h5555_5555; dinb = 32'h6666_6666;
            end
            @(posedge clk); #1;
        end
        clr_req = 0; ena = 0; enb = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL clr_done timeout: got no pulse within 40 cycles want pulse");
        end
        expv("busy cycles", n, 16);
        expv("busy0 at clr_done", busy[0], 0);
        expv("busy1 at clr_done", busy[1], 0);
        expv("clr_done1", clr_done[1], 1);
    endtask

    // Read every address on both ports, starting in the clr_done cycle.
    task automatic readback();
        for (int i = 0; i < 16; i++) begin
            drive(mkvec(1, 0, i[3:0], 0, 1, 0, 4'(15 - i), 0, CV0, CV1, CV0, CV1, 1, 1, 0), 1);
            if (i == 0) begin
                expv("clr_done0 one-cycle", clr_done[0], 0);
                expv("clr_done1 one-cycle", clr_done[1], 0);
            end
        end
        idle(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        ena wea   aa  dina          enb web   ab  dinb          xa0           xa1           xb0           xb1          ca cb xc
        tbl[0]  = mkvec(1, 4'hF, 3, 32'h11223344, 0, 4'h0, 0, 32'h0,        32'h00000000, 32'h11223344, 32'h0,        32'h0,        1, 0, 0);
        tbl[1]  = mkvec(1, 4'h2, 3, 32'hAAAAAAAA, 0, 4'h0, 0, 32'h0,        32'h11223344, 32'h1122AA44, 32'h0,        32'h0,        1, 0, 0);
        tbl[2]  = mkvec(1, 4'h0, 3, 32'h0,        1, 4'h0, 3, 32'h0,        32'h1122AA44, 32'h1122AA44, 32'h1122AA44, 32'h1122AA44, 1, 1, 0);
        tbl[3]  = mkvec(1, 4'hC, 5, 32'hFFFF0000, 1, 4'hF, 5, 32'h0000FFFF, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1);
        tbl[4]  = mkvec(1, 4'h0, 5, 32'h0,        1, 4'h0, 5, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0);
        tbl[5]  = mkvec(1, 4'hF, 7, 32'h00000001, 0, 4'h0, 0, 32'h0,        32'h00000000, 32'h00000001, 32'h0,        32'h0,        1, 0, 0);
        tbl[6]  = mkvec(1, 4'hF, 7, 32'h00000002, 1, 4'h0, 7, 32'h0,        32'h00000001, 32'h00000002, 32'h00000001, 32'h00000001, 1, 1, 0);
        tbl[7]  = mkvec(1, 4'h0, 7, 32'h0,        1, 4'h0, 7, 32'h0,        32'h00000002, 32'h00000002, 32'h00000002, 32'h00000002, 1, 1, 0);
        tbl[8]  = mkvec(1, 4'h0, 9, 32'h0,        1, 4'h5, 9, 32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEFEBE0D, 1, 1, 0);
        tbl[9]  = mkvec(1, 4'h0, 9, 32'h0,        1, 4'h0, 3, 32'h0,        32'h00FE000D, 32'hDEFEBE0D, 32'h1122AA44, 32'h1122AA44, 1, 1, 0);
        tbl[10] = mkvec(1, 4'h0, 5, 32'h0,        0, 4'h0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 0);

        rst_n = 1; ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0;
        dina = 0; dinb = 0; clr_req = 0;
        #3 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            expv("rst douta", douta[d], 0);
            expv("rst doutb", doutb[d], 0);
            expv("rst vlda", vlda[d], 0);
            expv("rst vldb", vldb[d], 0);
            expv("rst coll", coll[d], 0);
            expv("rst clr_done", clr_done[d], 0);
            expv("rst busy", busy[d], 1);
        end
        mon_en = 1;
        rst_n = 1;
        wait_clear(0);
        readback();

        for (int i = 0; i < 11; i++) drive(tbl[i], 1);
        idle(4);

        // Requested clear, ignored accesses and clr_req mid-clear, then reset.
        clr_req = 1;
        idle(1);
        clr_req = 0;
        expv("busy after clr_req", busy[0], 1);
        clr_req = 1;
        for (int i = 0; i < 4; i++) drive(mkvec(1, 4'hF, 2, 32'h12345678, 1, 4'h0, 2, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        clr_req = 0; ena = 0; enb = 0;
        rst_n = 0;
        #1;
        expv("midrst douta1", douta[1], 0);
        expv("midrst doutb1", doutb[1], 0);
        expv("midrst vlda1", vlda[1], 0);
        expv("midrst busy0", busy[0], 1);
        @(posedge clk); #1;
        rst_n = 1;
        wait_clear(1);
        readback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
